// File: rtl/mac_tx_framer.sv
// mac_tx_framer: gigabit Ethernet TX framer on a 16-bit word datapath
// Emits /S/+preamble+SFD, payload, zero pad, FCS, /T/R/ and an inter-frame gap toward an 8b10b SERDES.
// Low byte of every word goes on the line first.
// Ports:
//   clk, rst_n                    word clock, async active-low reset
//   pkt_dat/valid/last/ready      payload source handshake (valid in idle requests a frame)
//   crc_dat/crc_en/crc_rst        feed to the external CRC block; crc_out is its finished FCS
//   tx_dat/tx_kchar               registered SERDES word and per-byte K flags (bit0 = low byte)
//   tx_busy                       high from preamble through the end of the gap
//   underrun_err/oversize_err     one-cycle error pulses
//   frame_cnt                     frames completed with a valid FCS
module mac_tx_framer #(
  parameter int MIN_WORDS = 30,
  parameter int MAX_WORDS = 757,
  parameter int IFG_WORDS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pkt_dat,
  input  logic        pkt_valid,
  input  logic        pkt_last,
  output logic        pkt_ready,
  output logic [15:0] crc_dat,
  output logic        crc_en,
  output logic        crc_rst,
  input  logic [31:0] crc_out,
  output logic [15:0] tx_dat,
  output logic [1:0]  tx_kchar,
  output logic        tx_busy,
  output logic        underrun_err,
  output logic        oversize_err,
  output logic [15:0] frame_cnt
);
  typedef enum logic [3:0] {IDLE, PRE, DATA, PAD, FCS_HI, FCS_LO, TERM, DROP, IFG} state_t;
  localparam logic [15:0] IDLE_W = 16'h50BC;
  localparam logic [9:0]  MIN_W  = 10'(MIN_WORDS);
  localparam logic [9:0]  MAX_W  = 10'(MAX_WORDS);
  localparam logic [3:0]  IFG_W  = 4'(IFG_WORDS);
  state_t      state;
  logic [9:0]  wcnt;
  logic [3:0]  cnt;
  logic        under, over;
  logic [15:0] sel_dat;
  logic [1:0]  sel_k;
  assign pkt_ready = state == DATA || state == DROP;
  assign crc_en    = (state == DATA && pkt_valid) || state == PAD;
  assign crc_dat   = state == PAD ? 16'h0000 : pkt_dat;
  assign tx_busy   = state != IDLE;
  always_comb begin
    sel_dat = IDLE_W;
    sel_k   = 2'b01;
    case (state)
      PRE: begin
        sel_dat = cnt == 4'd0 ? 16'h55FB : cnt == 4'd3 ? 16'hD555 : 16'h5555;
        sel_k   = cnt == 4'd0 ? 2'b01 : 2'b00;
      end
      DATA: begin
        sel_dat = pkt_valid ? pkt_dat : 16'hFEFE;
        sel_k   = pkt_valid ? 2'b00 : 2'b11;
      end
      PAD: begin
        sel_dat = 16'h0000;
        sel_k   = 2'b00;
      end
      FCS_HI: begin
        sel_dat = crc_out[15:0];
        sel_k   = 2'b00;
      end
      FCS_LO: begin
        sel_dat = crc_out[31:16];
        sel_k   = 2'b00;
      end
      TERM: begin
        sel_dat = 16'hF7FD;
        sel_k   = 2'b11;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_dat       <= IDLE_W;
      tx_kchar     <= 2'b01;
      crc_rst      <= 1'b1;
      underrun_err <= 1'b0;
      oversize_err <= 1'b0;
      frame_cnt    <= 16'd0;
      wcnt         <= 10'd0;
      cnt          <= 4'd0;
      under        <= 1'b0;
      over         <= 1'b0;
    end else begin
      tx_dat       <= sel_dat;
      tx_kchar     <= sel_k;
      // preset lands at the end of the /S/ word so the CRC is clean for the first payload word
      crc_rst      <= state == IDLE && pkt_valid;
      underrun_err <= 1'b0;
      oversize_err <= 1'b0;
      case (state)
        IDLE: if (pkt_valid) begin
          state <= PRE;
          cnt   <= 4'd0;
        end
        PRE: begin
          wcnt  <= 10'd0;
          under <= 1'b0;
          over  <= 1'b0;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd3) state <= DATA;
        end
        DATA: if (!pkt_valid) begin
          underrun_err <= 1'b1;
          under        <= 1'b1;
          state        <= TERM;
        end else begin
          wcnt <= wcnt + 10'd1;
          if (pkt_last) state <= wcnt + 10'd1 < MIN_W ? PAD : FCS_HI;
          else if (wcnt == MAX_W - 10'd1) begin
            oversize_err <= 1'b1;
            over         <= 1'b1;
            state        <= FCS_HI;
          end
        end
        PAD: begin
          wcnt <= wcnt + 10'd1;
          if (wcnt == MIN_W - 10'd1) state <= FCS_HI;
        end
        FCS_HI: state <= FCS_LO;
        FCS_LO: state <= TERM;
        TERM: begin
          if (!under) frame_cnt <= frame_cnt + 16'd1;
          cnt   <= 4'd0;
          state <= over ? DROP : IFG;
        end
        DROP: if (pkt_valid && pkt_last) state <= IFG;
        IFG: begin
          cnt <= cnt + 4'd1;
          if (cnt == IFG_W - 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: scoreboard bench for mac_tx_framer with a behavioural CRC-32 block
module tb_mac_tx_framer;
  localparam logic [17:0] I2 = {2'b01, 16'h50BC};
  localparam logic [17:0] SW = {2'b01, 16'h55FB};
  localparam logic [17:0] TR = {2'b11, 16'hF7FD};
  localparam logic [17:0] VW = {2'b11, 16'hFEFE};
  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] pkt_dat = 0;
  logic        pkt_valid = 0, pkt_last = 0;
  logic        pkt_ready, crc_en, crc_rst, tx_busy, underrun_err, oversize_err;
  logic [15:0] crc_dat, tx_dat, frame_cnt;
  logic [31:0] crc_out, crc_r;
  logic [1:0]  tx_kchar;
  int errors = 0, checks = 0;
  logic [17:0] q[$];
  logic        in_frame = 0, mon_off = 0, ifg_run = 0;
  int en_cnt = 0, last_en = 0, gap = 0, last_gap = 0, ifg_cnt = 0;
  int n_under = 0, n_over = 0, exp_fc = 0;

  mac_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .pkt_dat(pkt_dat), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
    .pkt_ready(pkt_ready), .crc_dat(crc_dat), .crc_en(crc_en), .crc_rst(crc_rst), .crc_out(crc_out),
    .tx_dat(tx_dat), .tx_kchar(tx_kchar), .tx_busy(tx_busy), .underrun_err(underrun_err),
    .oversize_err(oversize_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  function automatic logic [31:0] crc16(input logic [31:0] c, input logic [15:0] w);
    return crc8(crc8(c, w[7:0]), w[15:8]);
  endfunction

  always_ff @(posedge clk)
    if (crc_rst) crc_r <= 32'hFFFFFFFF;
    else if (crc_en) crc_r <= crc16(crc_r, crc_dat);
  assign crc_out = ~crc_r;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [17:0] w, e;
    if (crc_rst) en_cnt = 0;
    else if (crc_en) en_cnt++;
    if (underrun_err) n_under++;
    if (oversize_err) n_over++;
    w = {tx_kchar, tx_dat};
    if (!rst_n || mon_off) in_frame = 0;
    else if (in_frame || w != I2) begin
      if (!in_frame) last_gap = gap;
      in_frame = 1;
      if (q.size() == 0) begin
        chk("extra_word", 32'(w), 32'(I2));
        in_frame = 0;
      end else begin
        e = q.pop_front();
        chk("tx_word", 32'(w), 32'(e));
        if (e == TR) begin
          in_frame = 0;
          last_en = en_cnt;
          gap = 0;
          ifg_run = 1;
          ifg_cnt = 0;
        end
      end
    end else gap++;
    if (ifg_run) begin
      if (tx_busy) ifg_cnt++;
      else ifg_run = 0;
    end
  end

  task automatic send(input int n, input int u);
    logic [15:0] pay[$];
    logic [31:0] c;
    logic x;
    int sent, i, lim;
    for (i = 0; i < n; i++) pay.push_back(16'($urandom));
    q.push_back(SW);
    q.push_back({2'b00, 16'h5555});
    q.push_back({2'b00, 16'h5555});
    q.push_back({2'b00, 16'hD555});
    if (u > 0) begin
      for (i = 0; i < u; i++) q.push_back({2'b00, pay[i]});
      q.push_back(VW);
      q.push_back(TR);
    end else begin
      c = 32'hFFFFFFFF;
      sent = n > 757 ? 757 : n;
      for (i = 0; i < sent; i++) begin
        q.push_back({2'b00, pay[i]});
        c = crc16(c, pay[i]);
      end
      for (i = sent; i < 30; i++) begin
        q.push_back(18'h0);
        c = crc16(c, 16'h0);
      end
      q.push_back({2'b00, ~c[15:0]});
      q.push_back({2'b00, ~c[31:16]});
      q.push_back(TR);
    end
    i = 0;
    lim = u > 0 ? u : n;
    for (int t = 0; i < lim && t < 5000; t++) begin
      pkt_valid = 1;
      pkt_dat = pay[i];
      pkt_last = u == 0 && i == n - 1;
      @(negedge clk);
      x = pkt_ready;
      @(posedge clk);
      #1;
      if (x) i++;
    end
    chk("xfer_count", 32'(i), 32'(lim));
    if (u > 0) begin
      pkt_valid = 0;
      pkt_last = 0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    pkt_valid = 0;
    pkt_last = 0;
    while ((tx_busy || q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done", 32'(tx_busy || q.size() != 0), 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, o0;
    repeat (3) @(negedge clk);
    chk("rst_tx_dat", 32'(tx_dat), 32'h50BC);
    chk("rst_kchar", 32'(tx_kchar), 32'h1);
    chk("rst_ready", 32'(pkt_ready), 0);
    chk("rst_crc_en", 32'(crc_en), 0);
    chk("rst_crc_rst", 32'(crc_rst), 1);
    chk("rst_errs", 32'({underrun_err, oversize_err}), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(negedge clk);
    // 64-byte frame, no pad
    send(32, 0);
    wait_done();
    exp_fc++;
    chk("f32_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("f32_crc_en", 32'(last_en), 32);
    chk("f32_ifg", 32'(ifg_cnt), 6);
    // short frame padded to 60 bytes
    send(14, 0);
    wait_done();
    exp_fc++;
    chk("f14_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("f14_crc_en", 32'(last_en), 30);
    // pad boundaries
    send(29, 0);
    wait_done();
    exp_fc++;
    chk("f29_crc_en", 32'(last_en), 30);
    send(30, 0);
    wait_done();
    exp_fc++;
    chk("f30_crc_en", 32'(last_en), 30);
    chk("f30_fcnt", 32'(frame_cnt), 32'(exp_fc));
    // underrun after 10 words
    u0 = n_under;
    send(20, 10);
    wait_done();
    chk("urun_pulse", 32'(n_under - u0), 1);
    chk("urun_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("urun_ifg", 32'(ifg_cnt), 6);
    // oversize: 800 offered, 757 framed, rest drained
    o0 = n_over;
    send(800, 0);
    wait_done();
    exp_fc++;
    chk("over_pulse", 32'(n_over - o0), 1);
    chk("over_crc_en", 32'(last_en), 757);
    chk("over_fcnt", 32'(frame_cnt), 32'(exp_fc));
    // last exactly on the maximum word is a normal frame
    o0 = n_over;
    send(757, 0);
    wait_done();
    exp_fc++;
    chk("max_no_over", 32'(n_over - o0), 0);
    chk("max_crc_en", 32'(last_en), 757);
    // back-to-back with valid held
    send(31, 0);
    send(32, 0);
    wait_done();
    exp_fc += 2;
    chk("b2b_gap", 32'(last_gap), 7);
    chk("b2b_fcnt", 32'(frame_cnt), 32'(exp_fc));
    // reset in the middle of DATA
    u0 = n_under;
    mon_off = 1;
    pkt_valid = 1;
    pkt_last = 0;
    pkt_dat = 16'h1234;
    for (int t = 0; t < 20 && !pkt_ready; t++) @(negedge clk);
    chk("mid_in_data", 32'(pkt_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_tx", 32'({tx_kchar, tx_dat}), 32'(I2));
    chk("mid_rst_ready", 32'(pkt_ready), 0);
    chk("mid_rst_crc_rst", 32'(crc_rst), 1);
    chk("mid_rst_fcnt", 32'(frame_cnt), 0);
    pkt_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(negedge clk);
    mon_off = 0;
    chk("mid_no_err", 32'(n_under - u0), 0);
    send(16, 0);
    wait_done();
    chk("post_rst_fcnt", 32'(frame_cnt), 1);
    chk("post_rst_crc_en", 32'(last_en), 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
